ram_uart_reader: RTL and testbench



---
 rtl/ram_uart_reader_if.sv | 23 ++
 rtl/ram_uart_reader.sv | 138 +++++++++++++
 tb/tb_ram_uart_reader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_uart_reader_if.sv
// RAM read port plus UART transmit handshake used by ram_uart_reader.
// The master side is the reader; the slave side is the RAM/transmitter pair.
interface ram_uart_reader_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] address_ram;
   logic [DATA_W-1:0] data_out_ram;
   logic              ram_req;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (
      output address_ram, ram_req, tx_data, tx_valid,
      input  data_out_ram, tx_ready
   );

   modport slave (
      input  address_ram, ram_req, tx_data, tx_valid,
      output data_out_ram, tx_ready
   );
endinterface

// File: rtl/ram_uart_reader.sv
// Streams an inclusive (wrapping) RAM address range to a UART transmitter.
// Define RAM_UART_READER_CHECKSUM_EN to append an 8-bit additive checksum byte.
module ram_uart_reader #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int RAM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   ram_uart_reader_if.master bus,
   output logic              busy,
   output logic              done
);

`ifdef RAM_UART_READER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, FETCH, SEND, CSUM, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
`endif

   // The wait counter runs 0..RAM_LATENCY, so FETCH lasts RAM_LATENCY+1 cycles.
   localparam logic [1:0] WAIT_LAST = 2'(RAM_LATENCY);

   state_t            state_reg;
   logic [ADDR_W-1:0] address_reg;
   logic [ADDR_W-1:0] end_addr_reg;
   logic [DATA_W-1:0] tx_data_reg;
   logic              tx_valid_reg;
   logic              ram_req_reg;
   logic              busy_reg;
   logic              done_reg;
   logic [1:0]        wait_cnt_reg;
`ifdef RAM_UART_READER_CHECKSUM_EN
   logic [DATA_W-1:0] sum_reg;
`endif

   assign bus.address_ram = address_reg;
   assign bus.tx_data     = tx_data_reg;
   assign bus.tx_valid    = tx_valid_reg;
   assign bus.ram_req     = ram_req_reg;
   assign busy            = busy_reg;
   assign done            = done_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         address_reg  <= '0;
         end_addr_reg <= '0;
         tx_data_reg  <= '0;
         tx_valid_reg <= 1'b0;
         ram_req_reg  <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         wait_cnt_reg <= '0;
`ifdef RAM_UART_READER_CHECKSUM_EN
         sum_reg      <= '0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  end_addr_reg <= end_addr;
                  address_reg  <= start_addr;
                  ram_req_reg  <= 1'b1;
                  busy_reg     <= 1'b1;
                  wait_cnt_reg <= '0;
`ifdef RAM_UART_READER_CHECKSUM_EN
                  sum_reg      <= '0;
`endif
                  state_reg    <= FETCH;
               end
            end

            FETCH: begin
               if (wait_cnt_reg == WAIT_LAST) begin
                  tx_data_reg  <= bus.data_out_ram;
                  tx_valid_reg <= 1'b1;
                  state_reg    <= SEND;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 2'd1;
               end
            end

            SEND: begin
               if (tx_valid_reg && bus.tx_ready) begin
`ifdef RAM_UART_READER_CHECKSUM_EN
                  sum_reg <= sum_reg + tx_data_reg;
`endif
                  if (address_reg == end_addr_reg) begin
`ifdef RAM_UART_READER_CHECKSUM_EN
                     // Checksum byte includes the byte being accepted right now.
                     tx_data_reg  <= sum_reg + tx_data_reg;
                     tx_valid_reg <= 1'b1;
                     state_reg    <= CSUM;
`else
                     tx_valid_reg <= 1'b0;
                     done_reg     <= 1'b1;
                     ram_req_reg  <= 1'b0;
                     busy_reg     <= 1'b0;
                     state_reg    <= DONE;
`endif
                  end else begin
                     tx_valid_reg <= 1'b0;
                     address_reg  <= address_reg + 1'b1;
                     wait_cnt_reg <= '0;
                     state_reg    <= FETCH;
                  end
               end
            end

`ifdef RAM_UART_READER_CHECKSUM_EN
            CSUM: begin
               if (tx_valid_reg && bus.tx_ready) begin
                  tx_valid_reg <= 1'b0;
                  done_reg     <= 1'b1;
                  ram_req_reg  <= 1'b0;
                  busy_reg     <= 1'b0;
                  state_reg    <= DONE;
               end
            end
`endif

            DONE: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_uart_reader.sv
// Randomised scoreboard bench for ram_uart_reader with a behavioural RAM model.
module tb_ram_uart_reader;
   parameter int LAT = 1;

`ifdef RAM_UART_READER_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] start_addr = '0;
   logic [15:0] end_addr = '0;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;
   int ready_pct = 100;
   int hs_cnt = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   logic [7:0] mem [0:65535];
   logic [7:0] rd1;
   logic [7:0] rd2;

   ram_uart_reader_if #(.ADDR_W(16), .DATA_W(8)) bus ();

   ram_uart_reader #(.ADDR_W(16), .DATA_W(8), .RAM_LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .end_addr   (end_addr),
      .bus        (bus.master),
      .busy       (busy),
      .done       (done)
   );

   initial forever #5 clk = ~clk;

   // Synchronous-read RAM with LAT cycles of read latency.
   always @(posedge clk) begin
      rd1 <= mem[bus.address_ram];
      rd2 <= rd1;
   end
   assign bus.data_out_ram = (LAT == 2) ? rd2 : rd1;

   initial begin
      bus.tx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.tx_ready = (int'($urandom_range(99)) < ready_pct);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: every address of the wrapping range in order, plus optional sum byte.
   task automatic push_expect(input logic [15:0] s, input logic [15:0] e);
      int          len;
      logic [7:0]  sum;
      logic [15:0] a;
      len = int'(16'(e - s)) + 1;
      sum = 8'h00;
      for (int i = 0; i < len; i++) begin
         a = 16'(s + i);
         exp_q.push_back('{a, mem[a]});
         sum = sum + mem[a];
      end
      if (CS == 1) exp_q.push_back('{e, sum});
   endtask

   // Monitor: handshake scoreboard plus hold-stable checks while stalled.
   initial begin
      logic        pv;
      logic        ph;
      logic [7:0]  pd;
      logic [15:0] pa;
      pv = 1'b0;
      ph = 1'b0;
      pd = '0;
      pa = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 1'b0;
            ph = 1'b0;
         end else begin
            if (pv && !ph) begin
               checks++;
               if (!bus.tx_valid) begin
                  failures++;
                  $display("FAIL valid_drop: tx_valid=0 required 1 (no handshake)");
               end else if (bus.tx_data !== pd || bus.address_ram !== pa) begin
                  failures++;
                  $display("FAIL hold_stable: data=%h addr=%h required data=%h addr=%h",
                           bus.tx_data, bus.address_ram, pd, pa);
               end
            end
            if (bus.tx_valid && bus.tx_ready) begin
               hs_cnt++;
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_byte: data=%h addr=%h required none", bus.tx_data, bus.address_ram);
               end else begin
                  mon_e = exp_q.pop_front();
                  if (bus.tx_data !== mon_e.d || bus.address_ram !== mon_e.a) begin
                     failures++;
                     $display("FAIL tx_byte: data=%h addr=%h required data=%h addr=%h",
                              bus.tx_data, bus.address_ram, mon_e.d, mon_e.a);
                  end else begin
                     $display("tx byte addr=%h data=%h", bus.address_ram, bus.tx_data);
                  end
               end
            end
            pv = bus.tx_valid;
            ph = bus.tx_valid && bus.tx_ready;
            pd = bus.tx_data;
            pa = bus.address_ram;
         end
      end
   end

   task automatic issue_start(input logic [15:0] s, input logic [15:0] e);
      int lat;
      @(posedge clk);
      #1;
      start = 1'b1;
      start_addr = s;
      end_addr = e;
      push_expect(s, e);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("addr_load", 32'(bus.address_ram), 32'(s));
      chk("busy_high", 32'(busy), 32'd1);
      chk("ram_req_high", 32'(bus.ram_req), 32'd1);
      lat = 0;
      while (!bus.tx_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("first_valid_latency", 32'(lat), 32'(LAT + 1));
   endtask

   task automatic wait_done(input int bound);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < bound) begin
         @(negedge clk);
         n++;
         seen = done;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL done_timeout: no done within %0d cycles, required one pulse", bound);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         exp_q.delete();
      end else begin
         chk("busy_at_done", 32'(busy), 32'd0);
         chk("ram_req_at_done", 32'(bus.ram_req), 32'd0);
         chk("queue_empty", 32'(exp_q.size()), 32'd0);
         // A start presented during the DONE cycle must be ignored.
         start = 1'b1;
         start_addr = 16'($urandom);
         end_addr = 16'($urandom);
         @(posedge clk);
         #1;
         start = 1'b0;
         @(negedge clk);
         chk("done_single", 32'(done), 32'd0);
         chk("busy_after_done", 32'(busy), 32'd0);
         chk("ram_req_idle", 32'(bus.ram_req), 32'd0);
         chk("tx_valid_idle", 32'(bus.tx_valid), 32'd0);
         $display("transfer complete after %0d cycles", n);
      end
   endtask

   initial begin
      int hs0;
      int n;
      logic [15:0] s;
      int len;

      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_addr", 32'(bus.address_ram), 32'd0);
      chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
      chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_ram_req", 32'(bus.ram_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Basic three-byte read.
      mem[16'h0010] = 8'hA1;
      mem[16'h0011] = 8'hB2;
      mem[16'h0012] = 8'hC3;
      ready_pct = 100;
      issue_start(16'h0010, 16'h0012);
      wait_done(200);

      // Transmitter stalls on the first byte.
      ready_pct = 0;
      issue_start(16'h0010, 16'h0012);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_data", 32'(bus.tx_data), 32'h0000_00A1);
         chk("stall_addr", 32'(bus.address_ram), 32'h0000_0010);
         chk("stall_valid", 32'(bus.tx_valid), 32'd1);
      end
      ready_pct = 100;
      wait_done(200);

      // Single byte at the top of the address space.
      mem[16'hFFFF] = 8'h5A;
      hs0 = hs_cnt;
      issue_start(16'hFFFF, 16'hFFFF);
      wait_done(200);
      chk("one_byte_count", 32'(hs_cnt - hs0), 32'(1 + CS));

      // Wrapping range.
      hs0 = hs_cnt;
      issue_start(16'hFFFE, 16'h0001);
      wait_done(200);
      chk("wrap_count", 32'(hs_cnt - hs0), 32'(4 + CS));

      // Asynchronous reset after the second handshake.
      hs0 = hs_cnt;
      issue_start(16'h0010, 16'h0012);
      n = 0;
      while (hs_cnt < hs0 + 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("reach_second_hs", 32'(hs_cnt - hs0), 32'd2);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_addr", 32'(bus.address_ram), 32'd0);
      chk("arst_tx_data", 32'(bus.tx_data), 32'd0);
      chk("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("arst_ram_req", 32'(bus.ram_req), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_done_in_reset", 32'(done), 32'd0);
      end
      rst = 1'b0;
      issue_start(16'h0010, 16'h0012);
      wait_done(200);

      // Checksum pattern (sum byte expected only when the feature is built in).
      mem[16'h0020] = 8'hFF;
      mem[16'h0021] = 8'h02;
      mem[16'h0022] = 8'h04;
      issue_start(16'h0020, 16'h0022);
      wait_done(200);

      // Random ranges, random back-pressure, start pulses while busy.
      for (int t = 0; t < 12; t++) begin
         ready_pct = int'($urandom_range(100, 30));
         len = int'($urandom_range(8, 1));
         s = (t % 3 == 0) ? 16'(16'hFFFF - 16'($urandom_range(4, 0))) : 16'($urandom);
         issue_start(s, 16'(s + 16'(len - 1)));
         start = 1'b1;
         start_addr = 16'($urandom);
         end_addr = 16'($urandom);
         @(posedge clk);
         #1;
         start = 1'b0;
         wait_done(60 * len + 100);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
